// File: rtl/spi_regfile_sync_if.sv
// rtl/spi_regfile_sync_if.sv - SPI-side memory bus between the SPI peripheral and the register file
interface spi_regfile_sync_if #(
  parameter int AWIDTH = 3,
  parameter int WIDTH  = 32
);
  logic [AWIDTH-1:0]  spi_addr;
  logic               spi_we;
  logic [WIDTH-1:0]   spi_wdata;
  logic [WIDTH/8-1:0] spi_wmask;
  logic [WIDTH-1:0]   spi_rdata;

  modport master (
    output spi_addr, spi_we, spi_wdata, spi_wmask,
    input  spi_rdata
  );

  modport slave (
    input  spi_addr, spi_we, spi_wdata, spi_wmask,
    output spi_rdata
  );
endinterface

// File: rtl/spi_regfile_sync.sv
// rtl/spi_regfile_sync.sv - SCK-to-clk synchronised byte-masked register file for the DVS core
// Optional read-only status word at NUM_REGS-1 when RF_STATUS_REG_EN is defined.
module spi_regfile_sync #(
  parameter int AWIDTH      = 3,
  parameter int WIDTH       = 32,
  parameter int NUM_REGS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  spi_regfile_sync_if.slave         bus,
  output logic [NUM_REGS*WIDTH-1:0] cfg_regs,
  output logic                      cfg_update,
  output logic [AWIDTH-1:0]         cfg_update_idx,
  output logic                      err_oob,
  input  logic [WIDTH-1:0]          status_in
);

  localparam int                NB         = WIDTH / 8;
  localparam logic [AWIDTH:0]   NUM_REGS_W = (AWIDTH + 1)'(NUM_REGS);
  localparam logic [AWIDTH-1:0] LAST_IDX   = AWIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] we_sync;
  logic                   we_s;
  logic                   we_d;
  logic [AWIDTH-1:0]      addr_sync [SYNC_STAGES];
  logic [AWIDTH-1:0]      addr_s;

  logic [AWIDTH-1:0]      hold_addr;
  logic [WIDTH-1:0]       hold_data;
  logic [NB-1:0]          hold_mask;

  logic [WIDTH-1:0]       regs [NUM_REGS];
  logic [WIDTH-1:0]       rdata_next;

  logic                   capture;
  logic                   commit_wr;
  logic                   commit_pulse;
  logic                   oob_set;
  logic                   hold_in_range;
  logic                   hold_is_status;

  assign we_s   = we_sync[SYNC_STAGES-1];
  assign addr_s = addr_sync[SYNC_STAGES-1];

  // Address is quasi-static during a frame, so a plain per-bit chain suffices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_sync <= '0;
      we_d    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) addr_sync[i] <= '0;
    end else begin
      we_sync      <= {we_sync[SYNC_STAGES-2:0], bus.spi_we};
      we_d         <= we_s;
      addr_sync[0] <= bus.spi_addr;
      for (int i = 1; i < SYNC_STAGES; i++) addr_sync[i] <= addr_sync[i-1];
    end
  end

  assign hold_in_range = ({1'b0, hold_addr} < NUM_REGS_W);
`ifdef RF_STATUS_REG_EN
  assign hold_is_status = (hold_addr == LAST_IDX);
`else
  assign hold_is_status = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    capture      = 1'b0;
    commit_wr    = 1'b0;
    commit_pulse = 1'b0;
    oob_set      = 1'b0;
    case (state)
      IDLE: begin
        if (we_s && !we_d) begin
          capture    = 1'b1;
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        state_next = WAIT_LOW;
        if (hold_in_range) begin
          commit_pulse = 1'b1;
          commit_wr    = !hold_is_status;
        end else begin
          oob_set = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!we_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_addr      <= '0;
      hold_data      <= '0;
      hold_mask      <= '0;
      cfg_update     <= 1'b0;
      cfg_update_idx <= '0;
      err_oob        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (capture) begin
        hold_addr <= bus.spi_addr;
        hold_data <= bus.spi_wdata;
        hold_mask <= bus.spi_wmask;
      end
      if (commit_wr) begin
        for (int b = 0; b < NB; b++) begin
          if (hold_mask[b]) regs[hold_addr][8*b +: 8] <= hold_data[8*b +: 8];
        end
      end
      cfg_update <= commit_pulse;
      if (commit_pulse) cfg_update_idx <= hold_addr;
      if (oob_set)      err_oob        <= 1'b1;
    end
  end

  always_comb begin
    rdata_next = '0;
    if ({1'b0, addr_s} < NUM_REGS_W) begin
      rdata_next = regs[addr_s];
`ifdef RF_STATUS_REG_EN
      if (addr_s == LAST_IDX) rdata_next = status_in;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.spi_rdata <= '0;
    else        bus.spi_rdata <= rdata_next;
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cfg
`ifdef RF_STATUS_REG_EN
    if (i == NUM_REGS - 1) begin : g_status
      assign cfg_regs[i*WIDTH +: WIDTH] = status_in;
    end else begin : g_rw
      assign cfg_regs[i*WIDTH +: WIDTH] = regs[i];
    end
`else
    assign cfg_regs[i*WIDTH +: WIDTH] = regs[i];
`endif
  end

`ifndef RF_STATUS_REG_EN
  logic unused_status;
  assign unused_status = ^status_in;
`endif

endmodule

// File: tb/tb_spi_regfile_sync.sv
// tb/tb_spi_regfile_sync.sv - directed table-driven bench for spi_regfile_sync (NUM_REGS=6)
module tb_spi_regfile_sync;
  localparam int AW = 3;
  localparam int W  = 32;
  localparam int NR = 6;
  localparam int SS = 2;

  logic          clk;
  logic          rst_n;
  logic [NR*W-1:0] cfg_regs;
  logic          cfg_update;
  logic [AW-1:0] cfg_update_idx;
  logic          err_oob;
  logic [W-1:0]  status_in;

  spi_regfile_sync_if #(.AWIDTH(AW), .WIDTH(W)) spi_bus ();

  spi_regfile_sync #(.AWIDTH(AW), .WIDTH(W), .NUM_REGS(NR), .SYNC_STAGES(SS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (spi_bus),
    .cfg_regs       (cfg_regs),
    .cfg_update     (cfg_update),
    .cfg_update_idx (cfg_update_idx),
    .err_oob        (err_oob),
    .status_in      (status_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            total = 0;
  int            bad   = 0;
  int            pulse_cnt = 0;
  logic [AW-1:0] last_idx = '0;
  logic [W-1:0]  pulse_word = '0;
  logic [W-1:0]  exp_mem [NR];

  always @(negedge clk) begin
    if (cfg_update) begin
      pulse_cnt  <= pulse_cnt + 1;
      last_idx   <= cfg_update_idx;
      pulse_word <= cfg_regs[cfg_update_idx*W +: W];
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [3:0]    wmask;
    int            hold;
    logic [W-1:0]  exp_reg;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [W-1:0] word(int i);
    return cfg_regs[i*W +: W];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) exp_mem[i] = '0;
`ifdef RF_STATUS_REG_EN
    exp_mem[NR-1] = status_in;
`endif
  endtask

  task automatic check_all_regs(input string name);
    for (int i = 0; i < NR; i++) check($sformatf("%s_w%0d", name, i), word(i), exp_mem[i]);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [3:0] m, input int hold);
    @(negedge clk);
    spi_bus.spi_addr  = a;
    spi_bus.spi_wdata = d;
    spi_bus.spi_wmask = m;
    spi_bus.spi_we    = 1'b1;
    repeat (hold) @(negedge clk);
    spi_bus.spi_we = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  int            p0;
  logic [W-1:0]  exp5;

  initial begin
    vecs[0] = '{addr: 3'd2, wdata: 32'hDEADBEEF, wmask: 4'hF, hold: 3, exp_reg: 32'hDEADBEEF};
    vecs[1] = '{addr: 3'd1, wdata: 32'h11223344, wmask: 4'hF, hold: 1, exp_reg: 32'h11223344};
    vecs[2] = '{addr: 3'd1, wdata: 32'hAAAAAAAA, wmask: 4'h4, hold: 5, exp_reg: 32'h11AA3344};
    vecs[3] = '{addr: 3'd0, wdata: 32'h12345678, wmask: 4'h0, hold: 2, exp_reg: 32'h00000000};
    vecs[4] = '{addr: 3'd0, wdata: 32'hCAFEBABE, wmask: 4'h3, hold: 4, exp_reg: 32'h0000BABE};
    vecs[5] = '{addr: 3'd4, wdata: 32'hFFFFFFFF, wmask: 4'h9, hold: 2, exp_reg: 32'hFF0000FF};
    vecs[6] = '{addr: 3'd2, wdata: 32'h00000000, wmask: 4'h2, hold: 6, exp_reg: 32'hDEAD00EF};

    status_in         = 32'h0000CAFE;
    spi_bus.spi_addr  = '0;
    spi_bus.spi_we    = 1'b0;
    spi_bus.spi_wdata = '0;
    spi_bus.spi_wmask = '0;
    rst_n             = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_update", {31'b0, cfg_update}, 32'h0);
    check("rst_idx", {29'b0, cfg_update_idx}, 32'h0);
    check("rst_oob", {31'b0, err_oob}, 32'h0);
    check("rst_rdata", spi_bus.spi_rdata, 32'h0);
    check_all_regs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      p0 = pulse_cnt;
      do_write(vecs[v].addr, vecs[v].wdata, vecs[v].wmask, vecs[v].hold);
      exp_mem[vecs[v].addr] = vecs[v].exp_reg;
      check($sformatf("v%0d_reg", v), word(int'(vecs[v].addr)), vecs[v].exp_reg);
      check($sformatf("v%0d_pulses", v), 32'(pulse_cnt - p0), 32'd1);
      check($sformatf("v%0d_idx", v), {29'b0, last_idx}, {29'b0, vecs[v].addr});
      check($sformatf("v%0d_pulse_word", v), pulse_word, vecs[v].exp_reg);
      check($sformatf("v%0d_rdata", v), spi_bus.spi_rdata, vecs[v].exp_reg);
    end
    check_all_regs("table");

    // Write latency: register changes on the 4th edge after the strobe rises.
    @(negedge clk);
    spi_bus.spi_addr  = 3'd3;
    spi_bus.spi_wdata = 32'h01020304;
    spi_bus.spi_wmask = 4'hF;
    spi_bus.spi_we    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("lat_before", word(3), 32'h0);
    check("lat_before_upd", {31'b0, cfg_update}, 32'h0);
    @(posedge clk);
    #1;
    check("lat_after", word(3), 32'h01020304);
    check("lat_upd_hi", {31'b0, cfg_update}, 32'h1);
    @(posedge clk);
    #1;
    check("lat_upd_lo", {31'b0, cfg_update}, 32'h0);
    @(negedge clk);
    spi_bus.spi_we = 1'b0;
    repeat (6) @(negedge clk);
    exp_mem[3] = 32'h01020304;

    // Read latency: SYNC_STAGES+1 edges from an address change.
    spi_bus.spi_addr = 3'd4;
    repeat (5) @(negedge clk);
    spi_bus.spi_addr = 3'd2;
    repeat (2) @(posedge clk);
    #1;
    check("rlat_old", spi_bus.spi_rdata, 32'hFF0000FF);
    @(posedge clk);
    #1;
    check("rlat_new", spi_bus.spi_rdata, 32'hDEAD00EF);

`ifdef RF_STATUS_REG_EN
    exp5 = 32'h0000CAFE;
`else
    exp5 = 32'hFFFFFFFF;
`endif
    p0 = pulse_cnt;
    do_write(3'd5, 32'hFFFFFFFF, 4'hF, 2);
    exp_mem[5] = exp5;
    check("w5_rdata", spi_bus.spi_rdata, exp5);
    check("w5_cfg", word(5), exp5);
    check("w5_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("w5_idx", {29'b0, last_idx}, 32'd5);
    check("w5_oob", {31'b0, err_oob}, 32'h0);

    p0 = pulse_cnt;
    do_write(3'd6, 32'h55555555, 4'hF, 3);
    check("oob_flag", {31'b0, err_oob}, 32'h1);
    check("oob_pulses", 32'(pulse_cnt - p0), 32'd0);
    check_all_regs("oob");

    p0 = pulse_cnt;
    do_write(3'd3, 32'h000000AB, 4'h1, 2);
    exp_mem[3] = 32'h010203AB;
    check("post_oob_reg", word(3), 32'h010203AB);
    check("post_oob_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("oob_sticky", {31'b0, err_oob}, 32'h1);

    spi_bus.spi_addr = 3'd7;
    repeat (4) @(negedge clk);
    check("rd_oob_zero", spi_bus.spi_rdata, 32'h0);

    // Reset while the FSM is in COMMIT: the captured write must be dropped.
    p0 = pulse_cnt;
    @(negedge clk);
    spi_bus.spi_addr  = 3'd3;
    spi_bus.spi_wdata = 32'hFFFFFFFF;
    spi_bus.spi_wmask = 4'hF;
    spi_bus.spi_we    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n          = 1'b0;
    spi_bus.spi_we = 1'b0;
    #1;
    model_reset();
    check("mrst_reg3", word(3), 32'h0);
    check("mrst_upd", {31'b0, cfg_update}, 32'h0);
    check("mrst_oob", {31'b0, err_oob}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("mrst_pulses", 32'(pulse_cnt - p0), 32'd0);
    check_all_regs("mrst");

    p0 = pulse_cnt;
    do_write(3'd1, 32'h5A5A5A5A, 4'hF, 2);
    check("after_rst_reg", word(1), 32'h5A5A5A5A);
    check("after_rst_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("after_rst_idx", {29'b0, last_idx}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
